// File: rtl/inv_pipe_pkg.sv
// inv_pipe_pkg: shared defaults and occupancy-width helper for inv_pipe
package inv_pipe_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/tr_inv_cell.sv
// tr_inv_cell: one-bit CMOS inverter, pmos/nmos switches when INV_PIPE_SWITCH_LEVEL_EN is defined
module tr_inv_cell (
    input  logic a_i,
    output wire  y_o
);
`ifdef INV_PIPE_SWITCH_LEVEL_EN
    supply1 vdd;
    supply0 gnd;
    pmos p_up (y_o, vdd, a_i);
    nmos n_dn (y_o, gnd, a_i);
`else
    assign y_o = ~a_i;
`endif
endmodule

// File: rtl/inv_pipe.sv
// inv_pipe: elastic DEPTH-stage per-lane masked inverter; INV_PIPE_SWITCH_LEVEL_EN selects switch-level inverters
module inv_pipe
    import inv_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] INIT_MASK = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      mask_we,
    input  logic [WIDTH-1:0]          mask_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);
    localparam int OW = occ_w(DEPTH);

    logic [WIDTH-1:0] mask_q, op_d;
    logic [DEPTH-1:0] vld_q, vld_d, acc;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [OW-1:0]    occ_q, occ_d;
    logic             in_hs, out_hs;

`ifdef INV_PIPE_SWITCH_LEVEL_EN
    wire [WIDTH-1:0] inv_op;
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        tr_inv_cell u_cell (.a_i(in_data[g]), .y_o(inv_op[g]));
    end
    assign op_d = (inv_op & mask_q) | (in_data & ~mask_q);
`else
    assign op_d = in_data ^ mask_q;
`endif

    // acc[k]: stage k can take a word this cycle (empty, or its word moves on)
    always_comb begin
        acc = '0;
        acc[DEPTH-1] = !vld_q[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) acc[k] = !vld_q[k] || acc[k+1];
        vld_d[0] = acc[0] ? in_valid : vld_q[0];
        dat_d[0] = (acc[0] && in_valid) ? op_d : dat_q[0];
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = acc[k] ? vld_q[k-1] : vld_q[k];
            dat_d[k] = (acc[k] && vld_q[k-1]) ? dat_q[k-1] : dat_q[k];
        end
    end

    assign in_ready  = acc[0];
    assign in_hs     = in_valid && acc[0];
    assign out_hs    = vld_q[DEPTH-1] && out_ready;
    assign occ_d     = occ_q + OW'(in_hs) - OW'(out_hs);
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            dat_q  <= '{default: '0};
            mask_q <= INIT_MASK;
            occ_q  <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            occ_q <= occ_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end
endmodule
